// File: rtl/pwm_fade_sequencer.sv
// PWM fade sequencer: enables one PWM channel over a simple local write bus, then
// ramps its duty-cycle register from a start value towards a target in fixed
// steps, idling a programmable number of clocks between duty updates.
module pwm_fade_sequencer #(
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         DATA_W      = 32,
    parameter logic [ADDR_W-1:0]   CH_SEL_BASE = ADDR_W'(32'h0),
    parameter logic [ADDR_W-1:0]   DUTY_BASE   = ADDR_W'(32'h10),
    parameter int unsigned         CH_STRIDE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            channel,
    input  logic [7:0]            start_dc,
    input  logic [7:0]            target_dc,
    input  logic [7:0]            step,
    input  logic [15:0]           interval,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [7:0]            cur_dc,
    output logic [ADDR_W-1:0]     waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  wen,
    output logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wready
);

    typedef enum logic [2:0] {StIdle, StEnWr, StDcWr, StWait, StFin} state_e;

    state_e          state_q, state_d;
    logic [1:0]      ch_q;
    logic [7:0]      target_q;
    logic [7:0]      step_q;
    logic [15:0]     interval_q;
    logic [15:0]     wait_cnt_q;
    logic            abort_pend_q;
    logic            aborted_q;
    logic [7:0]      next_dc;
    logic [8:0]      sum_up;
    logic [ADDR_W-1:0] ch_off;
    logic            abort_any;
    logic            leave_on_abort;

    assign abort_any = abort_pend_q | abort;
    assign ch_off    = ADDR_W'(ch_q) * ADDR_W'(CH_STRIDE);
    assign sum_up    = {1'b0, cur_dc} + {1'b0, step_q};

    // Only an abort can take EN_WR, DC_WR or WAIT straight back to IDLE.
    assign leave_on_abort = (state_d == StIdle) &&
                            ((state_q == StEnWr) || (state_q == StDcWr) || (state_q == StWait));

    // Next duty value: step towards the target, clamped so it never overshoots or wraps.
    always_comb begin
        next_dc = target_q;
        if (step_q != 8'd0) begin
            if (cur_dc < target_q) begin
                if (sum_up < {1'b0, target_q}) next_dc = sum_up[7:0];
            end else if (cur_dc > target_q) begin
                if ((cur_dc - target_q) > step_q) next_dc = cur_dc - step_q;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; reaching the target wins over a pending abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StEnWr;
            StEnWr: if (wready) state_d = abort_any ? StIdle : StDcWr;
            StDcWr: begin
                if (wready) begin
                    if (next_dc == target_q) state_d = StFin;
                    else if (abort_any)      state_d = StIdle;
                    else                     state_d = StWait;
                end
            end
            StWait: begin
                if (abort)                   state_d = StIdle;
                else if (wait_cnt_q <= 16'd1) state_d = StDcWr;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state; bus fields are zero when no write is requested.
    always_comb begin
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
        busy  = (state_q != StIdle);
        done  = (state_q == StFin);
        case (state_q)
            StEnWr: begin
                wen   = 1'b1;
                waddr = CH_SEL_BASE + ch_off;
                wdata = DATA_W'(1);
                wstrb = '1;
            end
            StDcWr: begin
                wen   = 1'b1;
                waddr = DUTY_BASE + ch_off;
                wdata = DATA_W'(next_dc);
                wstrb = '1;
            end
            default: ;
        endcase
    end

    assign aborted = aborted_q;

    // Fade parameters, current duty, wait counter and abort bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q         <= '0;
            target_q     <= '0;
            step_q       <= '0;
            interval_q   <= '0;
            cur_dc       <= '0;
            wait_cnt_q   <= '0;
            abort_pend_q <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            aborted_q <= leave_on_abort;
            if ((state_q == StIdle) && start) begin
                ch_q       <= channel;
                target_q   <= target_dc;
                step_q     <= step;
                interval_q <= interval;
                cur_dc     <= start_dc;
            end
            if ((state_q == StDcWr) && wready) begin
                cur_dc     <= next_dc;
                wait_cnt_q <= interval_q;
            end else if ((state_q == StWait) && (wait_cnt_q > 16'd1)) begin
                wait_cnt_q <= wait_cnt_q - 16'd1;
            end
            // An abort seen during a write is held until that write is accepted.
            if (state_d == StIdle) begin
                abort_pend_q <= 1'b0;
            end else if (abort && ((state_q == StEnWr) || (state_q == StDcWr))) begin
                abort_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed scenarios plus randomized fades checked
// against a duty-sequence model computed from plain integer arithmetic.
module tb_pwm_fade_sequencer;

    localparam int CH_SEL_BASE = 'h0;
    localparam int DUTY_BASE   = 'h10;
    localparam int CH_STRIDE   = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  channel;
    logic [7:0]  start_dc;
    logic [7:0]  target_dc;
    logic [7:0]  step;
    logic [15:0] interval;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  cur_dc;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    logic        wready;

    int passed;
    int total;
    int cyc;
    int done_cnt;
    int abort_cnt;
    int stab_err;
    logic        hold_pend;
    logic [31:0] hold_addr;
    logic [31:0] hold_data;
    logic [3:0]  hold_strb;
    int wr_addr[$];
    int wr_data[$];
    int wr_strb[$];
    int wr_cyc[$];

    pwm_fade_sequencer #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .CH_SEL_BASE (32'h0),
        .DUTY_BASE   (32'h10),
        .CH_STRIDE   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .channel   (channel),
        .start_dc  (start_dc),
        .target_dc (target_dc),
        .step      (step),
        .interval  (interval),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .cur_dc    (cur_dc),
        .waddr     (waddr),
        .wdata     (wdata),
        .wen       (wen),
        .wstrb     (wstrb),
        .wready    (wready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor at the falling edge: logs accepted writes, pulses and held-write stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend && !(wen && waddr == hold_addr && wdata == hold_data &&
                               wstrb == hold_strb)) stab_err <= stab_err + 1;
            if (wen && !busy) stab_err <= stab_err + 1;
            if (wen && wready) begin
                wr_addr.push_back(int'(waddr));
                wr_data.push_back(int'(wdata));
                wr_strb.push_back(int'(wstrb));
                wr_cyc.push_back(cyc);
            end
            hold_pend <= wen && !wready;
            hold_addr <= waddr;
            hold_data <= wdata;
            hold_strb <= wstrb;
            if (done)    done_cnt  <= done_cnt + 1;
            if (aborted) abort_cnt <= abort_cnt + 1;
        end
    end

    task automatic pulse_start(input int ch, input int sdc, input int tdc, input int stp,
                               input int intv);
        @(posedge clk); #1;
        channel = 2'(ch); start_dc = 8'(sdc); target_dc = 8'(tdc);
        step = 8'(stp); interval = 16'(intv); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the inputs to show the fade uses latched values.
        channel = 2'($urandom); start_dc = 8'($urandom); target_dc = 8'($urandom);
        step = 8'($urandom); interval = 16'($urandom_range(0, 7));
    endtask

    task automatic wait_idle(input string name, input bit rnd);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 20000) begin
            @(posedge clk); #1;
            if (rnd) wready = 1'($urandom);
            k++;
        end
        wready = 1'b1;
        total++;
        if (busy !== 1'b0) $display("FAIL %s_timeout: busy=%0b after %0d cycles want 0", name, busy, k);
        else passed++;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; channel = '0; start_dc = '0;
        target_dc = '0; step = '0; interval = '0; wready = 1'b1;
        #1;
        total += 8;
        if (busy !== 1'b0)    $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        if (wen !== 1'b0)     $display("FAIL reset_wen: got %0b want 0", wen); else passed++;
        if (waddr !== 32'h0)  $display("FAIL reset_waddr: got %0h want 0", waddr); else passed++;
        if (wdata !== 32'h0)  $display("FAIL reset_wdata: got %0h want 0", wdata); else passed++;
        if (wstrb !== 4'h0)   $display("FAIL reset_wstrb: got %0h want 0", wstrb); else passed++;
        if (done !== 1'b0)    $display("FAIL reset_done: got %0b want 0", done); else passed++;
        if (aborted !== 1'b0) $display("FAIL reset_aborted: got %0b want 0", aborted); else passed++;
        if (cur_dc !== 8'h0)  $display("FAIL reset_cur_dc: got %0d want 0", cur_dc); else passed++;
        repeat (2) @(posedge clk); #1;
        // Start presented together with reset release is taken on the very next edge.
        rst = 1'b0; channel = 2'd1; start_dc = 8'd9; target_dc = 8'd9; step = 8'd1;
        interval = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (wen !== 1'b1 || waddr !== 32'(CH_SEL_BASE + CH_STRIDE))
            $display("FAIL first_edge_start: wen=%0b waddr=%0h want 1/%0h", wen, waddr,
                     CH_SEL_BASE + CH_STRIDE);
        else passed++;
        wait_idle("first_edge", 1'b0);
        total++;
        if (cur_dc !== 8'd9) $display("FAIL equal_target_cur_dc: got %0d want 9", cur_dc);
        else passed++;
    endtask

    // One full fade compared against the duty sequence derived from the fade rules.
    task automatic test_fade(input string name, input int ch, input int sdc, input int tdc,
                             input int stp, input int intv, input bit rnd);
        int exp[$];
        int cur, nxt, n0, d0, a0, s0, gap;
        cur = sdc;
        do begin
            if (stp == 0 || cur == tdc) nxt = tdc;
            else if (cur < tdc)         nxt = (cur + stp > tdc) ? tdc : cur + stp;
            else                        nxt = (cur - stp < tdc) ? tdc : cur - stp;
            exp.push_back(nxt);
            cur = nxt;
        end while (nxt != tdc);
        n0 = wr_addr.size(); d0 = done_cnt; a0 = abort_cnt; s0 = stab_err;
        wready = rnd ? 1'($urandom) : 1'b1;
        pulse_start(ch, sdc, tdc, stp, intv);
        total++;
        if (wen !== 1'b1 || waddr !== 32'(CH_SEL_BASE + ch * CH_STRIDE))
            $display("FAIL %s_latency: wen=%0b waddr=%0h want 1/%0h", name, wen, waddr,
                     CH_SEL_BASE + ch * CH_STRIDE);
        else passed++;
        wait_idle(name, rnd);
        total++;
        if (wr_addr.size() - n0 != exp.size() + 1) begin
            $display("FAIL %s_write_count: got %0d want %0d", name, wr_addr.size() - n0,
                     exp.size() + 1);
            return;
        end else passed++;
        total++;
        if (wr_addr[n0] != CH_SEL_BASE + ch * CH_STRIDE || wr_data[n0] != 1 || wr_strb[n0] != 15)
            $display("FAIL %s_enable_write: addr=%0h data=%0h strb=%0h want %0h/1/f", name,
                     wr_addr[n0], wr_data[n0], wr_strb[n0], CH_SEL_BASE + ch * CH_STRIDE);
        else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (wr_addr[n0+1+i] != DUTY_BASE + ch * CH_STRIDE || wr_data[n0+1+i] != exp[i] ||
                wr_strb[n0+1+i] != 15)
                $display("FAIL %s_duty_%0d: addr=%0h data=%0d strb=%0h want %0h/%0d/f", name, i,
                         wr_addr[n0+1+i], wr_data[n0+1+i], wr_strb[n0+1+i],
                         DUTY_BASE + ch * CH_STRIDE, exp[i]);
            else passed++;
            if (!rnd) begin
                gap = (i == 0) ? 1 : ((intv == 0) ? 1 : intv) + 1;
                total++;
                if (wr_cyc[n0+1+i] - wr_cyc[n0+i] != gap)
                    $display("FAIL %s_gap_%0d: got %0d want %0d", name, i,
                             wr_cyc[n0+1+i] - wr_cyc[n0+i], gap);
                else passed++;
            end
        end
        total += 4;
        if (done_cnt - d0 != 1)  $display("FAIL %s_done: got %0d want 1", name, done_cnt - d0);
        else passed++;
        if (abort_cnt - a0 != 0) $display("FAIL %s_aborted: got %0d want 0", name, abort_cnt - a0);
        else passed++;
        if (cur_dc !== 8'(tdc))  $display("FAIL %s_cur_dc: got %0d want %0d", name, cur_dc, tdc);
        else passed++;
        if (stab_err != s0)      $display("FAIL %s_bus_stable: got %0d errs want 0", name,
                                          stab_err - s0);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n0, s0;
        n0 = wr_addr.size(); s0 = stab_err;
        wready = 1'b1;
        pulse_start(1, 0, 100, 40, 3);
        @(posedge clk); #1;
        wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (wen !== 1'b1 || waddr !== 32'(DUTY_BASE + CH_STRIDE) || wdata !== 32'd40)
                $display("FAIL bp_hold_%0d: wen=%0b addr=%0h data=%0d want 1/%0h/40", i, wen,
                         waddr, wdata, DUTY_BASE + CH_STRIDE);
            else passed++;
            @(posedge clk); #1;
        end
        wready = 1'b1;
        total++;
        if (wr_addr.size() - n0 != 1) $display("FAIL bp_not_early: got %0d writes want 1",
                                               wr_addr.size() - n0);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (wr_addr.size() - n0 != 2 || wr_data[wr_data.size()-1] != 40)
            $display("FAIL bp_complete_cycle6: writes=%0d want 2 with data 40", wr_addr.size() - n0);
        else passed++;
        wait_idle("bp", 1'b0);
        total += 2;
        if (cur_dc !== 8'd100) $display("FAIL bp_cur_dc: got %0d want 100", cur_dc); else passed++;
        if (stab_err != s0) $display("FAIL bp_stable: got %0d errs want 0", stab_err - s0);
        else passed++;
    endtask

    task automatic test_abort_wait();
        int n0, a0, d0, k;
        n0 = wr_addr.size(); a0 = abort_cnt; d0 = done_cnt;
        wready = 1'b1;
        pulse_start(2, 0, 100, 40, 3);
        k = 0;
        while (wr_addr.size() - n0 < 2 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total += 3;
        if (busy !== 1'b0)    $display("FAIL abw_busy: got %0b want 0", busy); else passed++;
        if (aborted !== 1'b1) $display("FAIL abw_pulse: got %0b want 1", aborted); else passed++;
        if (cur_dc !== 8'd40) $display("FAIL abw_cur_dc: got %0d want 40", cur_dc); else passed++;
        repeat (10) @(posedge clk); #1;
        total += 3;
        if (wr_addr.size() - n0 != 2) $display("FAIL abw_writes: got %0d want 2",
                                               wr_addr.size() - n0);
        else passed++;
        if (abort_cnt - a0 != 1) $display("FAIL abw_count: got %0d want 1", abort_cnt - a0);
        else passed++;
        if (done_cnt - d0 != 0) $display("FAIL abw_done: got %0d want 0", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_abort_write();
        int n0, a0, d0, k;
        n0 = wr_addr.size(); a0 = abort_cnt; d0 = done_cnt;
        wready = 1'b1;
        pulse_start(0, 0, 100, 40, 3);
        k = 0;
        while (wr_addr.size() - n0 < 1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        wready = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (2) @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || wen !== 1'b1) $display("FAIL abd_held: busy=%0b wen=%0b want 1/1",
                                                    busy, wen);
        else passed++;
        wready = 1'b1;
        wait_idle("abd", 1'b0);
        total += 4;
        if (cur_dc !== 8'd40) $display("FAIL abd_cur_dc: got %0d want 40", cur_dc); else passed++;
        if (wr_addr.size() - n0 != 2) $display("FAIL abd_writes: got %0d want 2",
                                               wr_addr.size() - n0);
        else passed++;
        if (abort_cnt - a0 != 1) $display("FAIL abd_count: got %0d want 1", abort_cnt - a0);
        else passed++;
        if (done_cnt - d0 != 0) $display("FAIL abd_done: got %0d want 0", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int n0, k;
        n0 = wr_addr.size();
        wready = 1'b1;
        pulse_start(0, 0, 100, 40, 3);
        k = 0;
        while (wr_addr.size() - n0 < 2 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        channel = 2'd3; start_dc = 8'd7; target_dc = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("ign", 1'b0);
        total += 2;
        if (wr_addr.size() - n0 != 4 || wr_addr[wr_addr.size()-1] != DUTY_BASE)
            $display("FAIL ign_writes: got %0d writes want 4 to ch0", wr_addr.size() - n0);
        else passed++;
        if (cur_dc !== 8'd100) $display("FAIL ign_cur_dc: got %0d want 100", cur_dc); else passed++;
    endtask

    task automatic test_reset_midwrite();
        wready = 1'b0;
        pulse_start(3, 20, 200, 5, 2);
        #2;
        rst = 1'b1;
        #1;
        total += 4;
        if (wen !== 1'b0)    $display("FAIL rstmid_wen: got %0b want 0", wen); else passed++;
        if (busy !== 1'b0)   $display("FAIL rstmid_busy: got %0b want 0", busy); else passed++;
        if (waddr !== 32'h0) $display("FAIL rstmid_waddr: got %0h want 0", waddr); else passed++;
        if (cur_dc !== 8'h0) $display("FAIL rstmid_cur_dc: got %0d want 0", cur_dc); else passed++;
        @(posedge clk); #1;
        rst = 1'b0; wready = 1'b1;
    endtask

    initial begin
        passed = 0; total = 0; cyc = 0; done_cnt = 0; abort_cnt = 0; stab_err = 0;
        hold_pend = 1'b0; hold_addr = '0; hold_data = '0; hold_strb = '0;
        test_reset();
        test_fade("basic", 2, 0, 100, 40, 3, 1'b0);
        test_fade("down", 1, 250, 5, 100, 2, 1'b0);
        test_fade("jump", 3, 10, 200, 0, 4, 1'b0);
        test_fade("int0", 0, 3, 9, 2, 0, 1'b0);
        test_backpressure();
        test_abort_wait();
        test_abort_write();
        test_start_ignored();
        test_reset_midwrite();
        test_fade("after_rst", 3, 20, 30, 7, 1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            test_fade("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 60)),
                      int'($urandom_range(0, 4)), 1'($urandom));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pwm_fade_sequencer.md
PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, local-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, local-bus data width; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter CH_SEL_BASE, default 32'h0, address of channel-0 enable register.
REQ-004 SHALL have parameter DUTY_BASE, default 32'h10, address of channel-0 duty-cycle register.
REQ-005 SHALL have parameter CH_STRIDE, default 4, byte offset between per-channel registers.
REQ-006 SHALL have ports, in this order:
  clk  input  1  sole clock, rising edge
  rst  input  1  asynchronous, active-high reset
  start  input  1  one-cycle request to begin a fade
  abort  input  1  stop the current fade
  channel  input  2  target PWM channel 0..3
  start_dc  input  8  initial duty cycle
  target_dc  input  8  final duty cycle
  step  input  8  duty increment per update
  interval  input  16  idle clocks between updates
  busy  output  1  high while not IDLE
  done  output  1  one-cycle pulse, fade reached target
  aborted  output  1  one-cycle pulse, fade stopped by abort
  cur_dc  output  8  last duty value written
  waddr  output  ADDR_W  bus write address
  wdata  output  DATA_W  bus write data
  wen  output  1  bus write request
  wstrb  output  STRB_W  byte strobes
  wready  input  1  bus write accept

Function
REQ-007 SHALL implement FSM states IDLE, EN_WR, DC_WR, WAIT, FIN.
REQ-008 In IDLE, start=1 SHALL latch channel, target_dc, step and interval, load cur_dc<=start_dc, and go to EN_WR; start outside IDLE SHALL be ignored.
REQ-009 EN_WR SHALL drive wen=1, waddr=CH_SEL_BASE+channel*CH_STRIDE, wdata=1, wstrb all ones.
REQ-010 DC_WR SHALL drive wen=1, waddr=DUTY_BASE+channel*CH_STRIDE, wdata={zeros,next_dc}, wstrb all ones.
REQ-011 A write SHALL complete on the rising edge where wen=1 and wready=1; waddr/wdata/wstrb SHALL stay stable while wen=1 and wready=0; wen SHALL be 0 in IDLE, WAIT and FIN.
REQ-012 next_dc SHALL be cur_dc+step if cur_dc<target_dc, cur_dc-step if cur_dc>target_dc, saturated to target_dc (no overshoot, no 8-bit wrap); cur_dc==target_dc SHALL give next_dc=target_dc.
REQ-013 step=0 SHALL be treated as a jump: next_dc=target_dc.
REQ-014 On EN_WR completion SHALL go to DC_WR; on DC_WR completion SHALL set cur_dc<=next_dc, then go to FIN if next_dc==target_dc, else WAIT.
REQ-015 WAIT SHALL hold exactly interval clocks, then go to DC_WR; interval=0 SHALL go from DC_WR completion to DC_WR on the next cycle (one cycle in WAIT).
REQ-016 FIN SHALL assert done for one cycle and return to IDLE.
REQ-017 abort in WAIT SHALL go to IDLE next cycle with aborted pulsed one cycle.
REQ-018 abort during EN_WR/DC_WR SHALL be latched; the pending write SHALL complete, then go to IDLE with aborted pulsed; cur_dc SHALL reflect a completed DC_WR.
REQ-019 abort in IDLE or FIN SHALL have no effect; abort and target reached in the same cycle SHALL give done, not aborted.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Latency: start at edge T SHALL give wen=1 (EN_WR) in the cycle after T.

Reset
REQ-022 rst=1 SHALL immediately force IDLE, wen=0, waddr=0, wdata=0, wstrb=0, busy=0, done=0, aborted=0, cur_dc=0 and clear the latched abort, including mid-write.
REQ-023 After rst deasserts, the first rising edge SHALL accept start.

Verification
REQ-024 start_dc=0, target=100, step=40, interval=3, ch=2, wready=1 -> write 1 @CH_SEL_BASE+8; duty 40, 80, 100 @DUTY_BASE+8, 3 idle clocks between duty writes; done once; cur_dc=100.
REQ-025 start_dc=250, target=5, step=100 -> duty writes 150, 50, 5; no wrap below 0.
REQ-026 wready held 0 for 5 cycles during first duty write -> waddr/wdata stable, wen high all 5 cycles, write completes on cycle 6.
REQ-027 abort mid-WAIT after duty 40 -> IDLE next cycle, aborted pulse, cur_dc=40, no further writes; abort with wready=0 in DC_WR -> that write completes, then aborted.
REQ-028 step=0, start_dc=10, target=200 -> one enable write, single duty write 200, done.
REQ-029 rst asserted while wen=1 and wready=0 -> wen=0 and busy=0 without waiting for a clock edge; new start after release -> normal fade.
